// File: rtl/hazard_ctrl_if.sv
// Decoder <-> hazard controller bundle: decoded-instruction fields in, issue/stall/flush decisions out.
// The stall/flush statistics counters exist only when HAZ_STATS_EN is defined.
interface hazard_ctrl_if #(
  parameter int REGAW = 4
);
  logic                    dec_valid;
  logic [REGAW-1:0]        dec_rn;
  logic [REGAW-1:0]        dec_rm;
  logic [REGAW-1:0]        dec_rd;
  logic                    dec_uses_rn;
  logic                    dec_uses_rm;
  logic                    dec_reg_we;
  logic                    dec_ib;
  logic                    dec_bl;
  logic                    issue_out;
  logic                    stall_out;
  logic                    flush_out;
  logic                    pc_redirect_out;
  logic                    ispb_out;
  logic [(2**REGAW)-1:0]   busy_out;
`ifdef HAZ_STATS_EN
  logic [31:0]             stall_cnt_out;
  logic [31:0]             flush_cnt_out;

  modport master (
    output dec_valid, dec_rn, dec_rm, dec_rd, dec_uses_rn, dec_uses_rm,
    output dec_reg_we, dec_ib, dec_bl,
    input  issue_out, stall_out, flush_out, pc_redirect_out, ispb_out, busy_out,
    input  stall_cnt_out, flush_cnt_out
  );

  modport slave (
    input  dec_valid, dec_rn, dec_rm, dec_rd, dec_uses_rn, dec_uses_rm,
    input  dec_reg_we, dec_ib, dec_bl,
    output issue_out, stall_out, flush_out, pc_redirect_out, ispb_out, busy_out,
    output stall_cnt_out, flush_cnt_out
  );
`else
  modport master (
    output dec_valid, dec_rn, dec_rm, dec_rd, dec_uses_rn, dec_uses_rm,
    output dec_reg_we, dec_ib, dec_bl,
    input  issue_out, stall_out, flush_out, pc_redirect_out, ispb_out, busy_out
  );

  modport slave (
    input  dec_valid, dec_rn, dec_rm, dec_rd, dec_uses_rn, dec_uses_rm,
    input  dec_reg_we, dec_ib, dec_bl,
    output issue_out, stall_out, flush_out, pc_redirect_out, ispb_out, busy_out
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: pending-write scoreboard (RAW/WAW), taken-branch flush sequencing, PC redirect.
// Optional HAZ_STATS_EN macro adds saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int REGAW    = 4,
  parameter int WB_LAT   = 3,
  parameter int BR_FLUSH = 2,
  parameter int LINK_REG = 14
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);
  localparam int NREG = 2 ** REGAW;
  localparam int CW   = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);
  localparam int FW   = (BR_FLUSH < 2) ? 1 : $clog2(BR_FLUSH + 1);
  localparam logic [REGAW-1:0] LINK_IDX = REGAW'(LINK_REG);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WB_LAT);
  localparam logic [FW-1:0]    FL_LOAD  = FW'(BR_FLUSH);
  localparam logic [FW-1:0]    FL_ONE   = FW'(1);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [FW-1:0]     fcnt_r, fcnt_s;
  logic              ispb_r, ispb_s;
  logic [CW-1:0]     cnt_r [NREG];
  logic [NREG-1:0]   busy_s;
  logic [NREG-1:0]   load_s;
  logic              haz_s, issue_s, stall_s, flush_s, redirect_s;

  // Busy vector and per-register scoreboard load strobes
  always_comb begin
    busy_s = {NREG{1'b0}};
    load_s = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      busy_s[i] = (cnt_r[i] != {CW{1'b0}});
      load_s[i] = issue_s &
                  ((hif.dec_reg_we & (hif.dec_rd == REGAW'(i))) |
                   (hif.dec_ib & hif.dec_bl & (LINK_IDX == REGAW'(i))));
    end
  end

  // Hazard detect from the current scoreboard (no forwarding path)
  always_comb begin
    haz_s = (hif.dec_uses_rn & busy_s[hif.dec_rn]) |
            (hif.dec_uses_rm & busy_s[hif.dec_rm]) |
            (hif.dec_reg_we  & busy_s[hif.dec_rd]) |
            (hif.dec_ib & hif.dec_bl & busy_s[LINK_IDX]);
  end

  // Next-state and issue/stall/flush decisions; everything is held low while reset is asserted
  always_comb begin
    state_s    = state_r;
    fcnt_s     = fcnt_r;
    ispb_s     = 1'b0;
    issue_s    = 1'b0;
    stall_s    = 1'b0;
    flush_s    = 1'b0;
    redirect_s = 1'b0;
    if (reset) begin
      state_s = RUN;
      fcnt_s  = {FW{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          issue_s = hif.dec_valid & ~haz_s;
          stall_s = hif.dec_valid & haz_s;
          if (issue_s & hif.dec_ib) begin
            redirect_s = 1'b1;
            if (BR_FLUSH == 0) begin
              ispb_s = 1'b1;
            end else begin
              state_s = FLUSH;
              fcnt_s  = FL_LOAD;
            end
          end else begin
            state_s = RUN;
          end
        end
        FLUSH: begin
          flush_s = 1'b1;
          if (fcnt_r <= FL_ONE) begin
            state_s = RUN;
            fcnt_s  = {FW{1'b0}};
          end else begin
            fcnt_s = fcnt_r - FL_ONE;
          end
        end
        default: begin
          state_s = RUN;
          fcnt_s  = {FW{1'b0}};
        end
      endcase
    end
  end

  // FSM state, flush countdown and the single-cycle ispb flag for zero-bubble branches
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      fcnt_r  <= {FW{1'b0}};
      ispb_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      fcnt_r  <= fcnt_s;
      ispb_r  <= ispb_s;
    end
  end

  // Scoreboard down-counters: a load wins over the decrement
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset) begin
        cnt_r[i] <= {CW{1'b0}};
      end else if (load_s[i]) begin
        cnt_r[i] <= CNT_LOAD;
      end else if (busy_s[i]) begin
        cnt_r[i] <= cnt_r[i] - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  assign hif.issue_out       = issue_s;
  assign hif.stall_out       = stall_s;
  assign hif.flush_out       = flush_s;
  assign hif.pc_redirect_out = redirect_s;
  assign hif.ispb_out        = ~reset & ((state_r == FLUSH) | ispb_r);
  assign hif.busy_out        = busy_s;

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // Saturating stall/flush cycle statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 32'h0000_0000;
    end else begin
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'h0000_0001;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hif.stall_cnt_out = stall_cnt_r;
  assign hif.flush_cnt_out = flush_cnt_r;
`endif
endmodule
